// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor feeding the crack datapath.
// Reads a length-prefixed plaintext (pt[0] = L, pt[1..L] = bytes) and writes
// the length-prefixed ciphertext to CT memory, using an external 256x8
// S-memory with 1-cycle synchronous read latency.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   en_i / rdy_o          start request / idle indication
//   key_i                 key, big-endian bytes, latched on accepted start
//   s_addr_o, s_rddata_i, s_wrdata_o, s_wren_o     S-memory
//   pt_addr_o, pt_rddata_i                         plaintext memory
//   ct_addr_o, ct_wrdata_o, ct_wren_o              ciphertext memory
module arc4_encrypt #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    output logic                   rdy_o,
    input  logic [8*KEY_BYTES-1:0] key_i,
    output logic [ADDR_W-1:0]      s_addr_o,
    input  logic [7:0]             s_rddata_i,
    output logic [7:0]             s_wrdata_o,
    output logic                   s_wren_o,
    output logic [ADDR_W-1:0]      pt_addr_o,
    input  logic [7:0]             pt_rddata_i,
    output logic [ADDR_W-1:0]      ct_addr_o,
    output logic [7:0]             ct_wrdata_o,
    output logic                   ct_wren_o
);

    typedef enum logic [3:0] {
        IDLE, INIT,
        KSA_RI, KSA_RJ, KSA_WI, KSA_WJ,
        LEN_RD, LEN_WR,
        P_RI, P_RJ, P_WI, P_WJ, P_RP, P_WR
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]             si_q, si_d, sj_q, sj_d, kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             kb, jn, pad_idx;

    // Current key byte, selected by the running i mod KEY_BYTES counter.
    always_comb begin
        kb = '0;
        for (int n = 0; n < KEY_BYTES; n++)
            if (kidx_q == 8'(n)) kb = key_q[8*(KEY_BYTES-n)-1 -: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        kidx_d      = kidx_q;
        key_d       = key_q;
        rdy_o       = 1'b0;
        s_addr_o    = '0;
        s_wrdata_o  = '0;
        s_wren_o    = 1'b0;
        pt_addr_o   = '0;
        ct_addr_o   = '0;
        ct_wrdata_o = '0;
        ct_wren_o   = 1'b0;
        jn          = '0;
        pad_idx     = si_q + sj_q;
        case (state_q)
            IDLE: begin
                rdy_o = 1'b1;
                if (en_i) begin
                    key_d   = key_i;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_addr_o   = ADDR_W'(i_q);
                s_wrdata_o = i_q;
                s_wren_o   = 1'b1;
                i_d        = i_q + 8'd1;   // wraps to 0 for KSA
                if (i_q == 8'd255) state_d = KSA_RI;
            end
            KSA_RI: begin
                s_addr_o = ADDR_W'(i_q);
                state_d  = KSA_RJ;
            end
            KSA_RJ: begin
                jn       = j_q + s_rddata_i + kb;
                j_d      = jn;
                si_d     = s_rddata_i;
                s_addr_o = ADDR_W'(jn);
                state_d  = KSA_WI;
            end
            // When i == j both writes store old S[i], so the entry is unchanged.
            KSA_WI: begin
                s_addr_o   = ADDR_W'(i_q);
                s_wrdata_o = s_rddata_i;
                s_wren_o   = 1'b1;
                state_d    = KSA_WJ;
            end
            KSA_WJ: begin
                s_addr_o   = ADDR_W'(j_q);
                s_wrdata_o = si_q;
                s_wren_o   = 1'b1;
                i_d        = i_q + 8'd1;
                kidx_d     = (kidx_q == 8'(KEY_BYTES-1)) ? 8'd0 : kidx_q + 8'd1;
                if (i_q == 8'd255) begin
                    j_d     = '0;
                    state_d = LEN_RD;
                end else begin
                    state_d = KSA_RI;
                end
            end
            LEN_RD: begin
                pt_addr_o = '0;
                state_d   = LEN_WR;
            end
            LEN_WR: begin
                ct_addr_o   = '0;
                ct_wrdata_o = pt_rddata_i;
                ct_wren_o   = 1'b1;
                len_d       = pt_rddata_i;
                k_d         = 8'd1;
                state_d     = (pt_rddata_i == 8'd0) ? IDLE : P_RI;
            end
            P_RI: begin
                i_d      = i_q + 8'd1;
                s_addr_o = ADDR_W'(i_d);
                state_d  = P_RJ;
            end
            P_RJ: begin
                jn       = j_q + s_rddata_i;
                j_d      = jn;
                si_d     = s_rddata_i;
                s_addr_o = ADDR_W'(jn);
                state_d  = P_WI;
            end
            P_WI: begin
                s_addr_o   = ADDR_W'(i_q);
                s_wrdata_o = s_rddata_i;
                s_wren_o   = 1'b1;
                sj_d       = s_rddata_i;
                state_d    = P_WJ;
            end
            P_WJ: begin
                s_addr_o   = ADDR_W'(j_q);
                s_wrdata_o = si_q;
                s_wren_o   = 1'b1;
                state_d    = P_RP;
            end
            // Swap does not change S[i]+S[j], so the pre-swap copies index the pad.
            P_RP: begin
                s_addr_o  = ADDR_W'(pad_idx);
                pt_addr_o = ADDR_W'(k_q);
                state_d   = P_WR;
            end
            P_WR: begin
                ct_addr_o   = ADDR_W'(k_q);
                ct_wrdata_o = pt_rddata_i ^ s_rddata_i;
                ct_wren_o   = 1'b1;
                // Compare before incrementing so L=255 ends without k overflowing.
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = P_RI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
